// File: rtl/vend_core_param.sv
// Vending controller core: coin credit, price table, dispense, change handshake, sales total.
// Latency: coin/selection/cancel act one cycle after the strobe; VEND lasts exactly one cycle.
// Backpressure: change held on change_valid until change_ack; strobes that cannot be honoured pulse alarm.
//
// Ports: clk/rst_n (async active-low); coin_valid/coin_code, sel_valid/sel_code, cancel,
//   price_wr/price_idx/price_data, change_ack, clear_sales in; credit, dispense/dispense_code,
//   change_valid/change_amt, alarm, busy, sales_total out.
// Optional feature macro: VEND_TIMEOUT_EN (idle auto-refund from CREDIT after TIMEOUT_CYC cycles).
module vend_core_param #(
   parameter int N_PROD      = 8,
   parameter int VAL_W       = 8,
   parameter int MAX_CREDIT  = 200,
   parameter int TIMEOUT_CYC = 1000,
   parameter int SALES_W     = VAL_W + 8,
   localparam int PW         = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coin_valid,
   input  logic [2:0]         coin_code,
   input  logic               sel_valid,
   input  logic [PW-1:0]      sel_code,
   input  logic               cancel,
   input  logic               price_wr,
   input  logic [PW-1:0]      price_idx,
   input  logic [VAL_W-1:0]   price_data,
   input  logic               change_ack,
   input  logic               clear_sales,
   output logic [VAL_W-1:0]   credit,
   output logic               dispense,
   output logic [PW-1:0]      dispense_code,
   output logic               change_valid,
   output logic [VAL_W-1:0]   change_amt,
   output logic               alarm,
   output logic               busy,
   output logic [SALES_W-1:0] sales_total
);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam logic [VAL_W:0] MAX_C  = MAX_CREDIT[VAL_W:0];
   localparam logic [PW:0]    NPROD  = N_PROD[PW:0];

   state_t               state_q, state_d;
   logic [VAL_W-1:0]     credit_q, credit_d;
   logic [PW-1:0]        sel_q, sel_d;
   logic                 alarm_q, alarm_d;
   logic [SALES_W-1:0]   sales_q, sales_d;
   logic [VAL_W-1:0]     price_q [N_PROD];

   logic                 coin_ok;
   logic [VAL_W:0]       coin_val;
   logic [VAL_W:0]       coin_sum;
   logic                 sel_in_range;
   logic [VAL_W-1:0]     sel_price;
   logic [VAL_W-1:0]     vend_price;
   logic [SALES_W:0]     sales_sum;

   // Denomination decode; codes 6 and 7 are rejected.
   always_comb begin
      coin_ok  = 1'b1;
      coin_val = '0;
      case (coin_code)
         3'd0:    coin_val = (VAL_W+1)'(1);
         3'd1:    coin_val = (VAL_W+1)'(2);
         3'd2:    coin_val = (VAL_W+1)'(5);
         3'd3:    coin_val = (VAL_W+1)'(10);
         3'd4:    coin_val = (VAL_W+1)'(20);
         3'd5:    coin_val = (VAL_W+1)'(50);
         default: coin_ok  = 1'b0;
      endcase
   end

   // One extra bit so an overflowing sum is caught before comparing to the bound.
   assign coin_sum     = {1'b0, credit_q} + coin_val;
   assign sel_in_range = ({1'b0, sel_code} < NPROD);
   assign sel_price    = sel_in_range ? price_q[sel_code] : '0;
   assign vend_price   = price_q[sel_q];
   assign sales_sum    = {1'b0, sales_q} + {{(SALES_W-VAL_W+1){1'b0}}, vend_price};

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;

   // Restarts on any coin or selection attempt; only counts while sitting in CREDIT.
   always_comb begin
      tmo_d = '0;
      if (state_q == CREDIT && !(coin_valid || sel_valid))
         tmo_d = tmo_q + 1'b1;
   end
   assign tmo_hit = (state_q == CREDIT) && (tmo_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`endif

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      sel_d    = sel_q;
      alarm_d  = 1'b0;
      case (state_q)
         IDLE, CREDIT: begin
            if (cancel && state_q == CREDIT) begin
               state_d = CHANGE;
            end else if (coin_valid) begin
               // A selection in the same cycle as a coin is silently dropped.
               if (coin_ok && coin_sum <= MAX_C) begin
                  credit_d = coin_sum[VAL_W-1:0];
                  state_d  = CREDIT;
               end else begin
                  alarm_d = 1'b1;
               end
            end else if (sel_valid) begin
               if (!sel_in_range || sel_price == '0 || credit_q < sel_price) begin
                  alarm_d = 1'b1;
               end else begin
                  sel_d   = sel_code;
                  state_d = VEND;
               end
            end
`ifdef VEND_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = CHANGE;
            end
`endif
         end
         VEND: begin
            credit_d = credit_q - vend_price;
            state_d  = (credit_q != vend_price) ? CHANGE : IDLE;
            if (coin_valid) alarm_d = 1'b1;
         end
         CHANGE: begin
            if (change_ack) begin
               credit_d = '0;
               state_d  = IDLE;
            end
            if (coin_valid) alarm_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (price_wr && state_q != IDLE) alarm_d = 1'b1;
   end

   // clear_sales wins over accumulation, but a sale in the same cycle still counts.
   always_comb begin
      sales_d = sales_q;
      if (clear_sales)
         sales_d = (state_q == VEND) ? {{(SALES_W-VAL_W){1'b0}}, vend_price} : '0;
      else if (state_q == VEND)
         sales_d = sales_sum[SALES_W] ? '1 : sales_sum[SALES_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         credit_q <= '0;
         sel_q    <= '0;
         alarm_q  <= 1'b0;
         sales_q  <= '0;
         for (int i = 0; i < N_PROD; i++) price_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         sel_q    <= sel_d;
         alarm_q  <= alarm_d;
         sales_q  <= sales_d;
         if (price_wr && state_q == IDLE && ({1'b0, price_idx} < NPROD))
            price_q[price_idx] <= price_data;
      end
   end

   assign credit        = credit_q;
   assign dispense      = (state_q == VEND);
   assign dispense_code = (state_q == VEND) ? sel_q : '0;
   assign change_valid  = (state_q == CHANGE);
   assign change_amt    = (state_q == CHANGE) ? credit_q : '0;
   assign alarm         = alarm_q;
   assign busy          = (state_q == VEND) || (state_q == CHANGE);
   assign sales_total   = sales_q;

endmodule

// File: tb/tb_vend_core_param.sv
// Directed bench for vend_core_param: stimulus queues expected events, a negedge monitor checks them.
// Latency: events are checked in the cycle the DUT presents them.
// Backpressure: change_ack is driven by the stimulus after the change event has been observed.
module tb_vend_core_param;

`ifdef VEND_TIMEOUT_EN
   localparam int TMO = 20;
`else
   localparam int TMO = 1000;
`endif

   localparam int K_DISP  = 0;
   localparam int K_CHG   = 1;
   localparam int K_ALARM = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        coin_valid = 1'b0;
   logic [2:0]  coin_code = '0;
   logic        sel_valid = 1'b0;
   logic [2:0]  sel_code = '0;
   logic        cancel = 1'b0;
   logic        price_wr = 1'b0;
   logic [2:0]  price_idx = '0;
   logic [7:0]  price_data = '0;
   logic        change_ack = 1'b0;
   logic        clear_sales = 1'b0;
   logic [7:0]  credit;
   logic        dispense;
   logic [2:0]  dispense_code;
   logic        change_valid;
   logic [7:0]  change_amt;
   logic        alarm;
   logic        busy;
   logic [15:0] sales_total;

   vend_core_param #(
      .N_PROD(8), .VAL_W(8), .MAX_CREDIT(200), .TIMEOUT_CYC(TMO), .SALES_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .coin_valid(coin_valid), .coin_code(coin_code),
      .sel_valid(sel_valid), .sel_code(sel_code),
      .cancel(cancel),
      .price_wr(price_wr), .price_idx(price_idx), .price_data(price_data),
      .change_ack(change_ack), .clear_sales(clear_sales),
      .credit(credit), .dispense(dispense), .dispense_code(dispense_code),
      .change_valid(change_valid), .change_amt(change_amt),
      .alarm(alarm), .busy(busy), .sales_total(sales_total)
   );

   always #5 clk = ~clk;

   typedef struct {int kind; int val;} ev_t;
   ev_t exp_q[$];
   int  nvec = 0;
   int  nmis = 0;
   logic prev_cv = 1'b0;

   task automatic check(input string nm, input int act, input int req);
      nvec++;
      if (act != req) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic push(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic take(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         nvec++;
         nmis++;
         $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_value", val, e.val);
      end
   endtask

   // Monitor: dispense and alarm are one-cycle pulses, change is reported on its rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dispense)                 take(K_DISP, int'(dispense_code));
         if (change_valid && !prev_cv) take(K_CHG, int'(change_amt));
         if (alarm)                    take(K_ALARM, 0);
      end
      prev_cv <= change_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic coin(input logic [2:0] c);
      coin_valid = 1'b1; coin_code = c; tick(); coin_valid = 1'b0;
   endtask

   task automatic sel(input logic [2:0] s);
      sel_valid = 1'b1; sel_code = s; tick(); sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1; tick(); cancel = 1'b0;
   endtask

   task automatic ack();
      change_ack = 1'b1; tick(); change_ack = 1'b0;
   endtask

   task automatic wprice(input logic [2:0] idx, input logic [7:0] d);
      price_wr = 1'b1; price_idx = idx; price_data = d; tick(); price_wr = 1'b0;
   endtask

   initial begin
      ticks(3);
      check("reset_credit", int'(credit), 0);
      check("reset_dispense", int'(dispense), 0);
      check("reset_change_valid", int'(change_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_sales", int'(sales_total), 0);
      rst_n = 1'b1;
      tick();

      // Basic sale with change.
      wprice(3'd3, 8'd15);
      coin(3'd3);
      check("credit_after_10", int'(credit), 10);
      coin(3'd3);
      check("credit_after_20", int'(credit), 20);
      push(K_DISP, 3);
      push(K_CHG, 5);
      sel(3'd3);
      check("busy_in_vend", int'(busy), 1);
      ticks(2);
      check("sales_after_sale", int'(sales_total), 15);
      ack();
      check("credit_after_ack", int'(credit), 0);
      check("change_valid_after_ack", int'(change_valid), 0);

      // Credit ceiling and invalid code.
      for (int i = 0; i < 4; i++) coin(3'd5);
      check("credit_at_max", int'(credit), 200);
      push(K_ALARM, 0);
      coin(3'd0);
      check("credit_after_overflow", int'(credit), 200);
      push(K_ALARM, 0);
      coin(3'd7);
      check("credit_after_bad_code", int'(credit), 200);
      push(K_CHG, 200);
      do_cancel();
      ticks(1);
      ack();

      // Unavailable product, insufficient credit, write outside IDLE, coin during CHANGE.
      coin(3'd2);
      push(K_ALARM, 0);
      sel(3'd0);
      push(K_ALARM, 0);
      sel(3'd3);
      push(K_ALARM, 0);
      wprice(3'd0, 8'd9);
      tick();
      check("credit_after_rejects", int'(credit), 5);
      push(K_CHG, 5);
      do_cancel();
      push(K_ALARM, 0);
      coin(3'd3);
      tick();
      ack();
      check("credit_after_cancel_ack", int'(credit), 0);

      // Exact-price sale with sales clear in the VEND cycle.
      coin(3'd3);
      coin(3'd2);
      push(K_DISP, 3);
      sel(3'd3);
      clear_sales = 1'b1; tick(); clear_sales = 1'b0;
      check("sales_clear_in_vend", int'(sales_total), 15);
      check("credit_exact_sale", int'(credit), 0);
      check("busy_after_exact", int'(busy), 0);
      ticks(3);

      // Idle credit: auto-refund only when the timeout is built.
      coin(3'd3);
`ifdef VEND_TIMEOUT_EN
      push(K_CHG, 10);
      ticks(TMO + 5);
      check("timeout_change_valid", int'(change_valid), 1);
      ack();
`else
      ticks(100);
      check("no_timeout_change_valid", int'(change_valid), 0);
      check("no_timeout_credit", int'(credit), 10);
      push(K_CHG, 10);
      do_cancel();
      ticks(1);
      ack();
`endif

      // Reset in the middle of a change: change drops at once, prices are wiped.
      coin(3'd4);
      push(K_CHG, 20);
      do_cancel();
      ticks(1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_change_valid", int'(change_valid), 0);
      check("reset_mid_change_credit", int'(credit), 0);
      tick();
      rst_n = 1'b1;
      tick();
      coin(3'd4);
      push(K_ALARM, 0);
      sel(3'd3);
      push(K_CHG, 20);
      do_cancel();
      ticks(1);
      ack();
      ticks(3);

      check("events_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/vend_core_param.md
# vend_core_param

Parametrised second-generation vending controller core. Accumulates coin credit from a denomination code, holds a writable per-product price table, dispenses on a valid selection, returns change through a held valid/ack handshake, and keeps a saturating sales total. It replaces the fixed 4-bit coin/product controller path under the top level and drives the existing display and alarm outputs.

## Interface
- `N_PROD`, 8: number of products; `sel_code`/`price_idx` width is `PW = $clog2(N_PROD)`, minimum 1.
- `VAL_W`, 8: width of credit, price and change values.
- `MAX_CREDIT`, 200: upper bound on accepted credit; must be below 2^VAL_W.
- `TIMEOUT_CYC`, 1000: idle cycles in CREDIT before auto-refund. Used only with `VEND_TIMEOUT_EN`.
- `SALES_W`, VAL_W+8: sales total width.

- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coin_valid` in 1: single-cycle coin strobe.
- `coin_code` in 3: denomination code. 0=1, 1=2, 2=5, 3=10, 4=20, 5=50; codes 6 and 7 are invalid.
- `sel_valid` in 1: single-cycle product selection strobe.
- `sel_code` in PW: selected product index.
- `cancel` in 1: refund request.
- `price_wr` in 1: price table write strobe.
- `price_idx` in PW: price table write index.
- `price_data` in VAL_W: price to write; 0 means the product is unavailable.
- `change_ack` in 1: change collected.
- `clear_sales` in 1: clears the sales total.
- `credit` out VAL_W: current credit.
- `dispense` out 1: one-cycle dispense pulse.
- `dispense_code` out PW: index of the dispensed product; valid while `dispense`=1.
- `change_valid` out 1: change pending; held high until acknowledged.
- `change_amt` out VAL_W: change value; stable while `change_valid`=1.
- `alarm` out 1: one-cycle error pulse.
- `busy` out 1: high in VEND or CHANGE.
- `sales_total` out SALES_W: accumulated sales.

## Operation
- **Reset:** state IDLE. All outputs 0. Price table all 0. Timeout counter 0.
- **States:** IDLE (credit is 0), CREDIT (credit > 0), VEND, CHANGE.
- **Priority in IDLE/CREDIT:** `cancel` > `coin_valid` > `sel_valid`. A selection in the same cycle as an accepted or rejected coin is dropped without an alarm.
- **Coin:**
  - Valid code and credit+value ≤ MAX_CREDIT: credit += value, go to CREDIT.
  - Invalid code or overflow: `alarm` pulses, credit unchanged.
- **Selection:**
  - `price[sel_code]`=0, or `sel_code` ≥ N_PROD, or credit < price: `alarm` pulses, no state change.
  - Otherwise: go to VEND.
- **VEND** (exactly one cycle):
  - `dispense`=1 and `dispense_code`=sel.
  - credit −= price.
  - `sales_total` += price, saturating at all-ones.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- **Cancel in CREDIT:** go to CHANGE with the full credit. Cancel in IDLE has no effect.
- **CHANGE:**
  - `change_valid`=1 and `change_amt`=credit.
  - On `change_ack`: credit becomes 0, `change_valid` drops, go to IDLE.
  - `change_ack` outside CHANGE is ignored.
- **Coins during VEND/CHANGE:** rejected with `alarm`. `sel_valid` and `cancel` are ignored there.
- **Price writes:** honoured only in IDLE. A write in any other state is ignored and pulses `alarm`.
- **`clear_sales`:** honoured in any state. Coincident with a VEND cycle, `sales_total` becomes that sale's price.
- **Alarm sources:** multiple sources in one cycle still give a single one-cycle pulse.

## Timing
- Coin accepted in cycle n: `credit` updated and visible at cycle n+1.
- Valid selection in cycle n: `dispense` high in cycle n+1. `change_valid` high from cycle n+2 when change is owed.
- `change_ack` in cycle m: `change_valid`=0 and `credit`=0 at m+1. The next coin is accepted from m+1.
- `alarm` rises the cycle after the offending strobe.
- `rst_n` asserted mid-vend or mid-change drops `dispense` and `change_valid` immediately. Credit is lost and no refund is issued.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A counter runs in CREDIT and restarts on any coin or selection attempt.
  - On reaching `TIMEOUT_CYC` the block enters CHANGE with the full credit, exactly as a cancel does.
  - The counter is cleared outside CREDIT.
- Undefined: no counter is built, and credit is held indefinitely.

## Test plan
- Reset, write `price[3]`=15 in IDLE, insert 10, then 10 → `credit` 10 then 20; select 3 → `dispense`=1, `dispense_code`=3, `sales_total`=15; `change_valid` with `change_amt`=5; `change_ack` → IDLE, `credit`=0.
- Coins of 50 four times (credit 200), then 1 → `alarm` pulse, `credit` stays 200. Invalid `coin_code` 7 → `alarm`, credit unchanged.
- Select product 0 with price 0 → `alarm`. Select product 3 (price 15) with credit 5 → `alarm`, no `dispense`.
- Insert 5, assert `cancel` → `change_amt`=5; insert a coin while in CHANGE → `alarm`; `change_ack` → IDLE.
- Exact-price sale (credit 15, price 15) → straight to IDLE, `change_valid` never asserted. `clear_sales` in the VEND cycle → `sales_total`=15.
- With `VEND_TIMEOUT_EN` and `TIMEOUT_CYC`=20: insert 10 and wait 20 cycles → `change_valid` with `change_amt`=10. Without the macro → no refund after 100 cycles.
